// File: rtl/ttl_7402_selftest_seq_if.sv
// Signal bundle between the 7402 self-test sequencer (master) and system control / the gate package (slave).
// With TTL7402_SEQ_LOOP_EN defined the bundle also carries loop_en and pass_count.
interface ttl_7402_selftest_seq_if;
  logic       start;
  logic [3:0] gate_a;
  logic [3:0] gate_b;
  logic [3:0] gate_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] fail_step;
  logic [3:0] fail_mask;
`ifdef TTL7402_SEQ_LOOP_EN
  logic       loop_en;
  logic [7:0] pass_count;

  modport master (
    input  start, gate_y, loop_en,
    output gate_a, gate_b, busy, done, pass, err_count, fail_step, fail_mask, pass_count
  );
  modport slave (
    output start, gate_y, loop_en,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_step, fail_mask, pass_count
  );
`else
  modport master (
    input  start, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, fail_step, fail_mask
  );
  modport slave (
    output start, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_step, fail_mask
  );
`endif
endinterface

// File: rtl/ttl_7402_selftest_seq.sv
// Walks a 16-step pattern through all four NOR gates of a 7402, compares Y against ~(A|B), and reports results.
// Optional continuous-loop mode is enabled by defining TTL7402_SEQ_LOOP_EN.
module ttl_7402_selftest_seq #(
  parameter int SETTLE_CYCLES = 16,
  parameter bit STOP_ON_ERROR = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  ttl_7402_selftest_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] step;
  logic [7:0] settle_cnt;
  logic [3:0] gate_a, gate_b;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] fail_step, fail_mask;

  logic [3:0] expected;
  logic [3:0] mism;
  logic       mism_any;
  logic       last_step;
  logic [4:0] err_next;
  logic       loop_back;

  // step[3:2] selects the gate under test; it sees vector v = step[1:0], the other gates see ~v.
  // Vector encoding (A,B): v0=00, v1=10, v2=01, v3=11, i.e. A = v[0], B = v[1].
  function automatic logic [7:0] drive_pattern(input logic [3:0] s);
    logic [3:0] a, b;
    a = '0;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == s[3:2]) begin
        a[i] = s[0];
        b[i] = s[1];
      end else begin
        a[i] = ~s[0];
        b[i] = ~s[1];
      end
    end
    return {a, b};
  endfunction

  assign expected  = ~(gate_a | gate_b);
  assign mism      = bus.gate_y ^ expected;
  assign mism_any  = |mism;
  assign last_step = (step == 4'd15);
  assign err_next  = err_count + 5'(mism_any);

`ifdef TTL7402_SEQ_LOOP_EN
  logic [7:0] pass_count;
  assign loop_back      = last_step && (err_next == 5'd0) && bus.loop_en;
  assign bus.pass_count = pass_count;
`else
  assign loop_back = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (bus.start) state_nxt = DRIVE;
      DRIVE:      state_nxt = SETTLE;
      SETTLE:     if (settle_cnt <= 8'd1) state_nxt = CHECK;
      CHECK: begin
        if (mism_any && STOP_ON_ERROR) state_nxt = DONE;
        else if (last_step)            state_nxt = loop_back ? DRIVE : DONE;
        else                           state_nxt = DRIVE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step       <= '0;
      settle_cnt <= '0;
      gate_a     <= '0;
      gate_b     <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_step  <= '0;
      fail_mask  <= '0;
`ifdef TTL7402_SEQ_LOOP_EN
      pass_count <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            step      <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_step <= '0;
            fail_mask <= '0;
          end
        end
        DRIVE: begin
          {gate_a, gate_b} <= drive_pattern(step);
          settle_cnt       <= 8'(SETTLE_CYCLES);
        end
        SETTLE: settle_cnt <= settle_cnt - 8'd1;
        CHECK: begin
          err_count <= err_next;
          // err_count==0 here means this is the first mismatch of the run.
          if (mism_any && err_count == 5'd0) begin
            fail_step <= step;
            fail_mask <= mism;
          end
          if (state_nxt == DONE) begin
            gate_a <= '0;
            gate_b <= '0;
            pass   <= (err_next == 5'd0);
          end else if (last_step) begin
            step      <= '0;
            err_count <= '0;
`ifdef TTL7402_SEQ_LOOP_EN
            pass_count <= pass_count + 8'd1;
`endif
          end else begin
            step <= step + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gate_a    = gate_a;
  assign bus.gate_b    = gate_b;
  assign bus.busy      = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.fail_step = fail_step;
  assign bus.fail_mask = fail_mask;

endmodule

// File: tb/tb_ttl_7402_selftest_seq.sv
// Self-checking bench for ttl_7402_selftest_seq: directed vector table, hand sequences and random stuck-at faults.
// Three instances: STOP_ON_ERROR=1 and 0 at SETTLE_CYCLES=16, and a SETTLE_CYCLES=1 run-all instance.
module tb_ttl_7402_selftest_seq;
  localparam int S_DEF  = 16;
  localparam int S_FAST = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sa0, sa1;
  int         total = 0;
  int         bad   = 0;
  int         sel   = 0;

  always #5 clk = ~clk;

  ttl_7402_selftest_seq_if if_s ();
  ttl_7402_selftest_seq_if if_r ();
  ttl_7402_selftest_seq_if if_f ();

  // Behavioural 7402 with injectable stuck-at-0 / stuck-at-1 outputs.
  assign if_s.gate_y = (~(if_s.gate_a | if_s.gate_b) & ~sa0) | sa1;
  assign if_r.gate_y = (~(if_r.gate_a | if_r.gate_b) & ~sa0) | sa1;
  assign if_f.gate_y = (~(if_f.gate_a | if_f.gate_b) & ~sa0) | sa1;

  ttl_7402_selftest_seq #(.SETTLE_CYCLES(S_DEF),  .STOP_ON_ERROR(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(if_s));
  ttl_7402_selftest_seq #(.SETTLE_CYCLES(S_DEF),  .STOP_ON_ERROR(1'b0)) dut_r (.clk(clk), .reset(reset), .bus(if_r));
  ttl_7402_selftest_seq #(.SETTLE_CYCLES(S_FAST), .STOP_ON_ERROR(1'b0)) dut_f (.clk(clk), .reset(reset), .bus(if_f));

`ifdef TTL7402_SEQ_LOOP_EN
  initial begin
    if_s.loop_en = 1'b0;
    if_r.loop_en = 1'b0;
    if_f.loop_en = 1'b0;
  end
`endif

  logic       busy_m, done_m, pass_m;
  logic [4:0] err_m;
  logic [3:0] step_m, mask_m, ga_m, gb_m;

  always_comb begin
    busy_m = if_s.busy; done_m = if_s.done; pass_m = if_s.pass; err_m = if_s.err_count;
    step_m = if_s.fail_step; mask_m = if_s.fail_mask; ga_m = if_s.gate_a; gb_m = if_s.gate_b;
    if (sel == 1) begin
      busy_m = if_r.busy; done_m = if_r.done; pass_m = if_r.pass; err_m = if_r.err_count;
      step_m = if_r.fail_step; mask_m = if_r.fail_mask; ga_m = if_r.gate_a; gb_m = if_r.gate_b;
    end else if (sel == 2) begin
      busy_m = if_f.busy; done_m = if_f.done; pass_m = if_f.pass; err_m = if_f.err_count;
      step_m = if_f.fail_step; mask_m = if_f.fail_mask; ga_m = if_f.gate_a; gb_m = if_f.gate_b;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0)      if_s.start = v;
    else if (s == 1) if_r.start = v;
    else             if_f.start = v;
  endtask

  function automatic int settle_of(input int s);
    return (s == 2) ? S_FAST : S_DEF;
  endfunction

  // Reference: which pins each step drives, straight from the vector table.
  function automatic logic [7:0] ref_drive(input int step);
    int         g, v;
    logic       va, vb;
    logic [3:0] a, b;
    g  = step / 4;
    v  = step % 4;
    va = (v == 1) || (v == 3);
    vb = (v == 2) || (v == 3);
    for (int i = 0; i < 4; i++) begin
      a[i] = (i == g) ? va : !va;
      b[i] = (i == g) ? vb : !vb;
    end
    return {a, b};
  endfunction

  // Reference: whole-run outcome for a given fault set.
  task automatic model_run(input int s, input logic [3:0] f0, input logic [3:0] f1,
                           output int edges, output int pass, output int err,
                           output int fstep, output int fmask);
    logic [7:0] d;
    logic [3:0] exp_y, y, m;
    int         last;
    err = 0; fstep = 0; fmask = 0; last = 15;
    for (int k = 0; k < 16; k++) begin
      d     = ref_drive(k);
      exp_y = ~(d[7:4] | d[3:0]);
      y     = (exp_y & ~f0) | f1;
      m     = y ^ exp_y;
      if (m != 0) begin
        if (err == 0) begin fstep = k; fmask = int'(m); end
        err++;
        if (s == 0) begin last = k; break; end
      end
    end
    edges = (last + 1) * (settle_of(s) + 2);
    pass  = (err == 0) ? 1 : 0;
  endtask

  // Start a run on instance s and follow it to DONE, checking the drive pattern every cycle.
  task automatic run_case(input int s, input string tag,
                          output int edges, output int pass, output int err,
                          output int fstep, output int fmask);
    int n, st, drive_bad, settle;
    logic [7:0] d;
    sel    = s;
    settle = settle_of(s);
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    #1;
    set_start(s, 1'b0);
    check({tag, "_start_flags"}, {busy_m, done_m, pass_m, err_m, step_m, mask_m}, {1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0});
    n = 0; drive_bad = 0; edges = -1;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (done_m) begin
        edges = n;
        break;
      end
      st = (n - 1) / (settle + 2);
      if (st < 16) begin
        d = ref_drive(st);
        if ({ga_m, gb_m} !== d) drive_bad++;
      end
    end
    if (edges < 0) $display("FAIL %s_timeout: no done within 2000 edges", tag);
    check({tag, "_drive"}, drive_bad, 0);
    check({tag, "_done_gates"}, {ga_m, gb_m, busy_m}, 9'd0);
    pass  = int'(pass_m);
    err   = int'(err_m);
    fstep = int'(step_m);
    fmask = int'(mask_m);
  endtask

  typedef struct {
    string      name;
    int         s;
    logic [3:0] f0, f1;
    int         edges, pass, err, fstep, fmask;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   e, p, er, fs, fm;
    int   me, mp, mer, mfs, mfm;
    int   n;

    vecs[0] = '{"clean_stop",   0, 4'b0000, 4'b0000, 288, 1, 0,  0, 0};
    vecs[1] = '{"y2_sa0_stop",  0, 4'b0010, 4'b0000,  72, 0, 1,  3, 4'b0010};
    vecs[2] = '{"restart_done", 0, 4'b0000, 4'b0000, 288, 1, 0,  0, 0};
    vecs[3] = '{"y4_sa1_run",   1, 4'b0000, 4'b1000, 288, 0, 12, 0, 4'b1000};
    vecs[4] = '{"clean_fast",   2, 4'b0000, 4'b0000,  48, 1, 0,  0, 0};
    vecs[5] = '{"y1_sa0_fast",  2, 4'b0001, 4'b0000,  48, 0, 4,  0, 4'b0001};

    reset = 1'b1; sa0 = '0; sa1 = '0;
    if_s.start = 1'b0; if_r.start = 1'b0; if_f.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check($sformatf("reset_state_%0d", s), {busy_m, done_m, pass_m, err_m, step_m, mask_m, ga_m, gb_m}, 26'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      sa0 = vecs[i].f0;
      sa1 = vecs[i].f1;
      run_case(vecs[i].s, vecs[i].name, e, p, er, fs, fm);
      check({vecs[i].name, "_edges"}, e,  vecs[i].edges);
      check({vecs[i].name, "_pass"},  p,  vecs[i].pass);
      check({vecs[i].name, "_err"},   er, vecs[i].err);
      check({vecs[i].name, "_fstep"}, fs, vecs[i].fstep);
      check({vecs[i].name, "_fmask"}, fm, vecs[i].fmask);
    end

    // Step-6 drive pattern and a start pulse mid-run that must be ignored.
    sa0 = '0; sa1 = '0; sel = 0;
    @(negedge clk); if_s.start = 1'b1;
    @(posedge clk); #1; if_s.start = 1'b0;
    n = 0; e = -1;
    while (n < 2000) begin
      @(negedge clk);
      if_s.start = (n == 49);
      @(posedge clk);
      n++;
      #1;
      if (n == 115) check("step6_drive", {ga_m, gb_m}, {4'b1101, 4'b0010});
      if (done_m) begin e = n; break; end
    end
    if_s.start = 1'b0;
    check("mid_start_edges", e, 288);
    check("mid_start_pass", {pass_m, err_m}, {1'b1, 5'd0});

    // Reset at edge 100 of a run, then a full clean run.
    @(negedge clk); if_s.start = 1'b1;
    @(posedge clk); #1; if_s.start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_run", {busy_m, done_m, pass_m, err_m, step_m, mask_m, ga_m, gb_m}, 26'd0);
    @(negedge clk); reset = 1'b0;
    run_case(0, "after_reset", e, p, er, fs, fm);
    check("after_reset_edges", e, 288);
    check("after_reset_pass", {p[0], er[4:0]}, {1'b1, 5'd0});

    // Random stuck-at faults against the reference model.
    for (int r = 0; r < 20; r++) begin
      int s;
      s   = int'($urandom_range(0, 2));
      sa0 = 4'($urandom);
      sa1 = 4'($urandom) & ~sa0;
      model_run(s, sa0, sa1, me, mp, mer, mfs, mfm);
      run_case(s, $sformatf("rnd%0d", r), e, p, er, fs, fm);
      check($sformatf("rnd%0d_edges", r), e, me);
      check($sformatf("rnd%0d_result", r), {p[0], er[4:0], fs[3:0], fm[3:0]},
            {mp[0], mer[4:0], mfs[3:0], mfm[3:0]});
    end
    sa0 = '0; sa1 = '0;

`ifdef TTL7402_SEQ_LOOP_EN
    begin
      int base, lbad;
      sel  = 2;
      base = int'(if_f.pass_count);
      lbad = 0;
      @(negedge clk); if_f.loop_en = 1'b1; if_f.start = 1'b1;
      @(posedge clk); #1; if_f.start = 1'b0;
      for (int k = 1; k <= 150; k++) begin
        @(posedge clk);
        #1;
        if (if_f.done || int'(if_f.pass_count) != ((base + k / 48) % 256)) lbad++;
      end
      check("loop_count_track", lbad, 0);
      @(negedge clk); if_f.loop_en = 1'b0;
      n = 150; e = -1;
      while (n < 2000) begin
        @(posedge clk);
        n++;
        #1;
        if (if_f.done) begin e = n; break; end
      end
      check("loop_exit_edges", e, 192);
      check("loop_exit_count", if_f.pass_count, 32'((base + 3) % 256));
      check("loop_exit_pass", {if_f.pass, if_f.err_count}, {1'b1, 5'd0});
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
